multi_channel_timer: RTL and testbench

Parametrised successor to the team's 8-bit compare/PWM timer. It provides a WIDTH-bit counter with a programmable period and shadowed reload, plus NUM_CH independent compare/PWM channels. It counts in up, centre-aligned up/down or one-shot mode, clocked either from a power-of-two prescaler or from edges of an external event. It sits on the peripheral side of the SoC, driving interrupt lines and PWM pins.

---
 rtl/multi_channel_timer.sv | 177 +++++++++++++++++
 tb/tb_multi_channel_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_timer.sv
// Multi-channel compare/PWM timer: WIDTH-bit counter with shadowed period/compares; up, up/down or one-shot counting.
// Outputs registered, pulses coincide with the new count; external events act on the 3rd clock after their rise; no backpressure.
module multi_channel_timer #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 2
) (
    input  logic                    i_clk,
    input  logic                    rst,
    input  logic                    i_timer_event,
    input  logic [3:0]              i_clk_control,
    input  logic [1:0]              i_mode_timer,
    input  logic [WIDTH-1:0]        i_period,
    input  logic [NUM_CH*WIDTH-1:0] i_compare,
    input  logic                    i_update,
    output logic [WIDTH-1:0]        o_count,
    output logic                    o_dir,
    output logic                    o_overflow,
    output logic [NUM_CH-1:0]       o_compare_interrupt,
    output logic [NUM_CH-1:0]       o_pwm,
    output logic                    o_running
);

    typedef enum logic [1:0] {
        MODE_STOP    = 2'd0,
        MODE_UP      = 2'd1,
        MODE_UPDN    = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_t             w_mode;
    mode_t             r_mode;
    logic [WIDTH-1:0]  r_count;
    logic              r_dir;
    logic              r_overflow;
    logic              r_running;
    logic [NUM_CH-1:0] r_cmp_irq;
    logic [6:0]        r_presc;
    logic [2:0]        r_ev_sync;
    logic [WIDTH-1:0]  r_period;
    logic [WIDTH-1:0]  r_cmp [NUM_CH];

    logic [6:0]        w_presc_mask;
    logic              w_presc_tick;
    logic              w_ev_rise;
    logic              w_tick;
    logic              w_enter;
    logic              w_dir_eff;
    logic              w_run_eff;
    logic [WIDTH-1:0]  w_count_nxt;
    logic              w_dir_nxt;
    logic              w_run_nxt;
    logic              w_wrap;
    logic              w_act;
    logic              w_load;
    logic [NUM_CH-1:0] w_irq;

    assign w_mode       = mode_t'(i_mode_timer);
    assign w_presc_mask = 7'((8'd1 << i_clk_control[2:0]) - 8'd1);
    assign w_presc_tick = (r_presc == w_presc_mask);
    // r_ev_sync[1:0] is the synchroniser, r_ev_sync[2] the previous synchronised level
    assign w_ev_rise    = r_ev_sync[1] & ~r_ev_sync[2];
    assign w_tick       = (w_mode != MODE_STOP) && (i_clk_control[3] ? w_ev_rise : w_presc_tick);
    assign w_enter      = (w_mode != r_mode);
    assign w_dir_eff    = (w_enter && w_mode != MODE_STOP) ? 1'b0 : r_dir;
    assign w_run_eff    = ((w_enter || i_update) && w_mode == MODE_ONESHOT) ? 1'b1 : r_running;
    assign w_load       = i_update || w_wrap || (w_mode == MODE_STOP);

    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = w_dir_eff;
        w_run_nxt   = w_run_eff;
        w_wrap      = 1'b0;
        w_act       = 1'b0;
        if (w_tick) begin
            case (w_mode)
                MODE_UP: begin
                    w_act = 1'b1;
                    if (r_count >= r_period) begin
                        w_count_nxt = '0;
                        w_wrap      = 1'b1;
                    end else begin
                        w_count_nxt = r_count + ONE;
                    end
                end
                MODE_ONESHOT: begin
                    if (w_run_eff) begin
                        w_act = 1'b1;
                        if (r_count >= r_period) begin
                            w_count_nxt = '0;
                            w_wrap      = 1'b1;
                            w_run_nxt   = 1'b0;
                        end else begin
                            w_count_nxt = r_count + ONE;
                        end
                    end
                end
                MODE_UPDN: begin
                    w_act = 1'b1;
                    if (r_period == '0) begin
                        w_count_nxt = '0;
                        w_dir_nxt   = 1'b0;
                        w_wrap      = 1'b1;
                    end else if (!w_dir_eff) begin
                        if (r_count >= r_period) begin
                            w_dir_nxt   = 1'b1;
                            w_count_nxt = r_period - ONE;
                        end else begin
                            w_count_nxt = r_count + ONE;
                        end
                    end else if (r_count == '0) begin
                        w_dir_nxt   = 1'b0;
                        w_count_nxt = ONE;
                        w_wrap      = 1'b1;
                    end else begin
                        w_count_nxt = r_count - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_irq = '0;
        o_pwm = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_irq[k] = w_act && (w_count_nxt == r_cmp[k]);
            o_pwm[k] = (r_mode != MODE_STOP) && (r_count < r_cmp[k]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_mode     <= MODE_STOP;
            r_count    <= '0;
            r_dir      <= 1'b0;
            r_overflow <= 1'b0;
            r_cmp_irq  <= '0;
            r_running  <= 1'b0;
            r_presc    <= '0;
            r_ev_sync  <= '0;
            r_period   <= '1;
            for (int k = 0; k < NUM_CH; k++) r_cmp[k] <= '0;
        end else begin
            r_mode    <= w_mode;
            r_ev_sync <= {r_ev_sync[1:0], i_timer_event};
            r_presc   <= (i_update || w_mode == MODE_STOP || w_presc_tick) ? '0 : r_presc + 7'd1;
            // a forced reload wins over any tick arriving in the same cycle
            if (i_update) begin
                r_count    <= '0;
                r_dir      <= 1'b0;
                r_running  <= w_run_eff;
                r_overflow <= 1'b0;
                r_cmp_irq  <= '0;
            end else begin
                r_count    <= w_count_nxt;
                r_dir      <= w_dir_nxt;
                r_running  <= w_run_nxt;
                r_overflow <= w_wrap;
                r_cmp_irq  <= w_irq;
            end
            if (w_load) begin
                r_period <= i_period;
                for (int k = 0; k < NUM_CH; k++) r_cmp[k] <= i_compare[k*WIDTH +: WIDTH];
            end
        end
    end

    assign o_count             = r_count;
    assign o_dir               = r_dir;
    assign o_overflow          = r_overflow;
    assign o_compare_interrupt = r_cmp_irq;
    assign o_running           = r_running;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: directed and random segments checked against closed-form
// count/phase arithmetic derived from the timer's counting rules.
module tb_multi_channel_timer;

    logic        i_clk;
    logic        rst;
    logic        i_timer_event;
    logic [3:0]  i_clk_control;
    logic [1:0]  i_mode_timer;
    logic [7:0]  i_period;
    logic [15:0] i_compare;
    logic        i_update;
    logic [7:0]  o_count;
    logic        o_dir;
    logic        o_overflow;
    logic [1:0]  o_compare_interrupt;
    logic [1:0]  o_pwm;
    logic        o_running;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int exp_run = 0;

    multi_channel_timer #(.WIDTH(8), .NUM_CH(2)) dut (
        .i_clk               (i_clk),
        .rst                 (rst),
        .i_timer_event       (i_timer_event),
        .i_clk_control       (i_clk_control),
        .i_mode_timer        (i_mode_timer),
        .i_period            (i_period),
        .i_compare           (i_compare),
        .i_update            (i_update),
        .o_count             (o_count),
        .o_dir               (o_dir),
        .o_overflow          (o_overflow),
        .o_compare_interrupt (o_compare_interrupt),
        .o_pwm               (o_pwm),
        .o_running           (o_running)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, want);
        end
    endtask

    task automatic check_outputs(input string tag, input int cnt, input int dr, input int ovf,
                                 input int irq, input int pwm, input int run);
        chk({tag, "_count"}, 32'(o_count), cnt);
        chk({tag, "_dir"},   32'(o_dir), dr);
        chk({tag, "_ovf"},   32'(o_overflow), ovf);
        chk({tag, "_irq"},   32'(o_compare_interrupt), irq);
        chk({tag, "_pwm"},   32'(o_pwm), pwm);
        chk({tag, "_run"},   32'(o_running), run);
    endtask

    // Stop, load shadows and zero the counter so a segment starts from a known point.
    task automatic prep(input int p, input int c0, input int c1);
        i_mode_timer = 2'd0;
        i_period     = 8'(p);
        i_compare    = {8'(c1), 8'(c0)};
        i_update     = 1'b1;
        @(posedge i_clk); #1;
        chk("prep_count", 32'(o_count), 0);
        chk("prep_ovf", 32'(o_overflow), 0);
        chk("prep_pwm", 32'(o_pwm), 0);
        i_update = 1'b0;
    endtask

    // After c clocks in mode m the counter has seen k = c / 2^n ticks; the count is a function of k alone.
    task automatic follow(input int m, input int n, input int p, input int c0, input int c1,
                          input int s, input int cycles);
        i_mode_timer  = 2'(m);
        i_clk_control = {1'b0, 3'(n)};
        for (int c = 1; c <= cycles; c++) begin
            int k, ph, cnt, dr, ovf, irq, pwm;
            bit tk, act;
            @(posedge i_clk); #1;
            k   = c >> n;
            tk  = (c % (1 << n)) == 0;
            act = tk;
            dr  = 0;
            ovf = 0;
            if (m == 1) begin
                cnt = (s + k) % (p + 1);
                ovf = (tk && cnt == 0) ? 1 : 0;
            end else if (m == 2) begin
                if (p == 0) begin
                    cnt = 0;
                    ovf = tk ? 1 : 0;
                end else begin
                    ph  = k % (2 * p);
                    cnt = (ph <= p) ? ph : 2 * p - ph;
                    dr  = ((ph > p) || (ph == 0 && k > 0)) ? 1 : 0;
                    ovf = (tk && ph == 1 && k > 1) ? 1 : 0;
                end
            end else begin
                cnt     = (k <= p) ? k : 0;
                ovf     = (tk && k == p + 1) ? 1 : 0;
                act     = tk && (k <= p + 1);
                exp_run = (k <= p) ? 1 : 0;
            end
            irq = ((act && cnt == c0) ? 1 : 0) | ((act && cnt == c1) ? 2 : 0);
            pwm = ((cnt < c0) ? 1 : 0) | ((cnt < c1) ? 2 : 0);
            check_outputs($sformatf("m%0d_c%0d", m, c), cnt, dr, ovf, irq, pwm, exp_run);
        end
    endtask

    initial begin
        rst           = 1'b1;
        i_timer_event = 1'b0;
        i_clk_control = 4'd0;
        i_mode_timer  = 2'd2;
        i_period      = 8'd17;
        i_compare     = 16'h0304;
        i_update      = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // up counting, period 9, compare0 4, compare1 beyond the period
        prep(9, 4, 200);
        follow(1, 0, 9, 4, 200, 0, 25);

        // centre-aligned, period 5, compare0 above period, compare1 3
        prep(5, 7, 3);
        follow(2, 0, 5, 7, 3, 0, 25);

        // prescaled up counting, compare1 zero keeps pwm1 low
        prep(4, 2, 0);
        follow(1, 2, 4, 2, 0, 0, 30);

        // one-shot, then re-arm with i_update while staying in mode 3
        prep(3, 1, 2);
        follow(3, 0, 3, 1, 2, 0, 8);
        i_update = 1'b1;
        @(posedge i_clk); #1;
        exp_run = 1;
        check_outputs("rearm", 0, 0, 0, 0, 3, 1);
        i_update = 1'b0;
        follow(3, 0, 3, 1, 2, 0, 8);

        // i_update beats a simultaneous tick: no overflow or compare pulse even with compare0 = 0
        prep(9, 0, 5);
        follow(1, 0, 9, 0, 5, 0, 6);
        i_update = 1'b1;
        @(posedge i_clk); #1;
        check_outputs("upd_prio", 0, 0, 0, 0, 2, exp_run);
        i_update = 1'b0;
        follow(1, 0, 9, 0, 5, 0, 12);

        // external event source: prescale exponent ignored, count moves on the 3rd edge after a rise
        prep(255, 5, 255);
        i_mode_timer  = 2'd1;
        i_clk_control = 4'b1111;
        @(posedge i_clk); #1;
        chk("ext_idle", 32'(o_count), 0);
        for (int i = 1; i <= 10; i++) begin
            i_timer_event = 1'b1;
            for (int e = 1; e <= 5; e++) begin
                @(posedge i_clk); #1;
                chk("ext_cnt", 32'(o_count), (e >= 3) ? i : i - 1);
                chk("ext_irq", 32'(o_compare_interrupt), (e == 3 && i == 5) ? 1 : 0);
            end
            i_timer_event = 1'b0;
            repeat (3) begin
                @(posedge i_clk); #1;
                chk("ext_low", 32'(o_count), i);
            end
        end
        chk("ext_total", 32'(o_count), 10);

        // period shadow lowered mid-count: old period completes, new one applies after the wrap
        prep(200, 30, 250);
        follow(1, 0, 200, 30, 250, 0, 100);
        i_period = 8'd20;
        for (int j = 1; j <= 148; j++) begin
            int tot, cnt;
            @(posedge i_clk); #1;
            tot = 100 + j;
            cnt = (tot <= 200) ? tot : (tot - 201) % 21;
            check_outputs("pchg", cnt, 0, (cnt == 0) ? 1 : 0, (cnt == 30) ? 1 : 0,
                          ((cnt < 30) ? 1 : 0) | 2, exp_run);
        end
        i_mode_timer = 2'd0;
        i_period     = 8'd50;
        repeat (3) begin
            @(posedge i_clk); #1;
            check_outputs("hold", 5, 0, 0, 0, 0, exp_run);
        end
        follow(1, 0, 50, 30, 250, 5, 60);

        // synchronous reset mid-count in up/down mode, then counting resumes from zero
        prep(200, 60, 10);
        follow(2, 0, 200, 60, 10, 0, 120);
        rst = 1'b1;
        @(posedge i_clk); #1;
        exp_run = 0;
        check_outputs("midrst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        follow(2, 0, 255, 0, 0, 0, 30);

        // randomised segments
        for (int r = 0; r < 8; r++) begin
            int m, n, p, c0, c1;
            m  = int'($urandom_range(3, 1));
            n  = int'($urandom_range(3, 0));
            p  = int'($urandom_range(40, 0));
            c0 = int'($urandom_range(p + 2, 0));
            c1 = int'($urandom_range(p + 2, 0));
            prep(p, c0, c1);
            follow(m, n, p, c0, c1, 0, (4 * p + 6) << n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
